invader_march_ctrl: RTL and testbench
=====================================

# invader_march_ctrl

Sequencer for the alien formation. While the game-running flag from the start/lose FSM is high, it counts frame ticks, then issues the formation's march steps. Each step moves the formation one horizontal stride; at the screen edge it drops the formation one row and reverses direction. The block speeds up as aliens are destroyed and raises `Invaded` when the formation reaches the player row, which feeds the lose condition.

## Interface
- `X_INIT`, 10'd32: formation left-edge X after reset or game start.
- `Y_INIT`, 10'd48: formation top-edge Y after reset or game start.
- `X_STEP`, 10'd8: horizontal stride per step.
- `X_MIN`, 10'd16: leftmost legal X.
- `X_MAX`, 10'd400: rightmost legal X (left-edge coordinate).
- `Y_STEP`, 10'd16: drop per edge hit.
- `Y_LIMIT`, 10'd400: Y at or beyond which the formation has invaded.
- `MIN_PERIOD`, 6'd2: fastest step period, in ticks.

Ports:
- `CLK` in 1: system clock. All state changes on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `En` in 1: game running (the start FSM's running flag), level-sensitive.
- `Tick` in 1: one-cycle frame strobe.
- `Alive` in 6: aliens remaining, 0..55.
- `X_pos` out 10: formation X, registered.
- `Y_pos` out 10: formation Y, registered.
- `Dir` out 1: 1 = moving right, 0 = moving left.
- `Step` out 1: one-cycle pulse on every position update, for sound and animation frame.
- `Invaded` out 1: formation reached `Y_LIMIT`. Sticky until the game ends.

## Operation
- States: IDLE, WAIT, MOVE, DESCEND, DONE.
- Reset values:
  - state IDLE
  - `X_pos`=`X_INIT`, `Y_pos`=`Y_INIT`
  - `Dir`=1, `Step`=0, `Invaded`=0
  - tick counter=0
- IDLE:
  - Positions, `Dir` and counter are held at reset values.
  - `En`=1 → WAIT.
- WAIT: counts `Tick` pulses.
  - Period P = `MIN_PERIOD` + `Alive` (7-bit sum, no saturation needed).
  - When the count reaches P-1 and `Tick`=1: clear the counter, then go to MOVE if the next X is in range, otherwise DESCEND.
  - `Alive`=0: the counter holds and no steps are issued (level cleared; the block waits for `En` to drop).
- MOVE:
  - `X_pos` += `X_STEP` if `Dir`=1, else `X_pos` −= `X_STEP`.
  - `Step`=1.
  - → WAIT.
- In range:
  - `Dir`=1: `X_pos`+`X_STEP` ≤ `X_MAX`.
  - `Dir`=0: `X_pos` ≥ `X_MIN`+`X_STEP`.
  - Compare in 11 bits so there is no wrap.
- DESCEND:
  - `Y_pos` += `Y_STEP`, `Dir` toggles, `X_pos` unchanged, `Step`=1.
  - If `Y_pos`+`Y_STEP` ≥ `Y_LIMIT` (11-bit compare): `Invaded`=1 → DONE.
  - Otherwise → WAIT.
- DONE: positions frozen, `Invaded` held at 1, no `Step`.
- `En`=0 in any state except IDLE:
  - Next edge goes to IDLE.
  - Positions, `Dir` and counter reload to reset values; `Invaded` clears.
  - This takes priority over all other transitions, including a coincident `Tick`.
- `Alive` is sampled only at the period compare. A change mid-period takes effect at the next compare. If the new P-1 is already below the current count, the step fires on the next `Tick`: use `count ≥ P-1`.

## Timing
- Latency from the qualifying `Tick` edge:
  - WAIT→MOVE/DESCEND on that edge.
  - The position update and `Step` are registered on the following edge.
  - Total: 2 cycles from `Tick` sampled to new `X_pos`/`Y_pos` visible.
- `Step` is high for exactly one cycle, the same cycle the new position first appears.
- `Tick` pulses arriving while in MOVE/DESCEND are ignored (1-cycle states).
- `Invaded` rises in the same cycle as the final `Y_pos` update.
- Asynchronous `RST` mid-step returns all outputs to reset values immediately, with no partial update.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle:
  - Stimulus: assert `RST`, release with `En`=0, apply 20 `Tick`s.
  - Required: `X_pos`=32, `Y_pos`=48, `Dir`=1, `Step`/`Invaded`=0 throughout.
- Step period:
  - Stimulus: `En`=1, `Alive`=10 (P=12).
  - Required: first `Step` appears 2 cycles after the 12th `Tick`, with `X_pos`=40. The second `Step` follows after 12 more `Tick`s, with `X_pos`=48.
- Right edge:
  - Stimulus: preload by stepping until `X_pos`=400.
  - Required: the next step gives `Y_pos`=64, `Dir`=0, `X_pos`=400. The step after that gives `X_pos`=392.
- Left edge:
  - Stimulus: march left to `X_pos`=16.
  - Required: the next step descends, `Dir`=1, `X_pos` stays 16.
- Invasion:
  - Stimulus: march until `Y_pos`=384, then trigger an edge hit.
  - Required: `Y_pos`=400, `Invaded`=1, state DONE. No further `Step` for 200 `Tick`s.
  - Then drop `En` for 1 cycle: all outputs return to reset values and `Invaded`=0.
- Speed-up, `Alive`=0 and priority:
  - Change `Alive` from 40 to 0 mid-period: stepping halts.
  - With `Alive`=1 (P=3): `Step` every 3 `Tick`s.
  - Drop `En` on the same cycle as the qualifying `Tick`: no `Step`, state goes to IDLE.

Source files
------------

// File: rtl/invader_march_ctrl.sv
// Alien formation march sequencer: counts frame ticks while the game runs, then
// steps the formation sideways, drops it a row at each edge, and flags invasion.
module invader_march_ctrl #(
    parameter logic [9:0] X_INIT     = 10'd32,
    parameter logic [9:0] Y_INIT     = 10'd48,
    parameter logic [9:0] X_STEP     = 10'd8,
    parameter logic [9:0] X_MIN      = 10'd16,
    parameter logic [9:0] X_MAX      = 10'd400,
    parameter logic [9:0] Y_STEP     = 10'd16,
    parameter logic [9:0] Y_LIMIT    = 10'd400,
    parameter logic [5:0] MIN_PERIOD = 6'd2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       En,
    input  logic       Tick,
    input  logic [5:0] Alive,
    output logic [9:0] X_pos,
    output logic [9:0] Y_pos,
    output logic       Dir,
    output logic       Step,
    output logic       Invaded
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        MOVE    = 3'd2,
        DESCEND = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     state_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       dir_q;
    logic       step_q;
    logic       invaded_q;
    logic [6:0] cnt_q;

    logic [6:0]  period_d;
    logic [6:0]  period_m1_d;
    logic [10:0] x_right_d;
    logic [10:0] x_left_min_d;
    logic [10:0] y_next_d;
    logic        in_range_d;
    logic        invade_d;

    // Period is widened to 7 bits so MIN_PERIOD + 55 cannot wrap.
    assign period_d     = {1'b0, MIN_PERIOD} + {1'b0, Alive};
    assign period_m1_d  = period_d - 7'd1;
    assign x_right_d    = {1'b0, x_q} + {1'b0, X_STEP};
    assign x_left_min_d = {1'b0, X_MIN} + {1'b0, X_STEP};
    assign in_range_d   = dir_q ? (x_right_d <= {1'b0, X_MAX})
                                : ({1'b0, x_q} >= x_left_min_d);
    assign y_next_d     = {1'b0, y_q} + {1'b0, Y_STEP};
    assign invade_d     = (y_next_d >= {1'b0, Y_LIMIT});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            x_q       <= X_INIT;
            y_q       <= Y_INIT;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            invaded_q <= 1'b0;
            cnt_q     <= 7'd0;
        end else begin
            step_q <= 1'b0;
            // Leaving the game outranks every other transition, even a due step.
            if (state_q != IDLE && !En) begin
                state_q   <= IDLE;
                x_q       <= X_INIT;
                y_q       <= Y_INIT;
                dir_q     <= 1'b1;
                invaded_q <= 1'b0;
                cnt_q     <= 7'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (En) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (Tick && (Alive != 6'd0)) begin
                            if (cnt_q >= period_m1_d) begin
                                cnt_q   <= 7'd0;
                                state_q <= in_range_d ? MOVE : DESCEND;
                            end else begin
                                cnt_q <= cnt_q + 7'd1;
                            end
                        end
                    end
                    MOVE: begin
                        x_q     <= dir_q ? (x_q + X_STEP) : (x_q - X_STEP);
                        step_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                    DESCEND: begin
                        y_q    <= y_next_d[9:0];
                        dir_q  <= ~dir_q;
                        step_q <= 1'b1;
                        if (invade_d) begin
                            invaded_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign X_pos   = x_q;
    assign Y_pos   = y_q;
    assign Dir     = dir_q;
    assign Step    = step_q;
    assign Invaded = invaded_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Scoreboard bench for invader_march_ctrl: the driver queues the expected
// position for each due step, a negedge monitor checks every Step pulse.
module tb_invader_march_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       En;
    logic       Tick;
    logic [5:0] Alive;
    logic [9:0] X_pos;
    logic [9:0] Y_pos;
    logic       Dir;
    logic       Step;
    logic       Invaded;

    invader_march_ctrl dut (
        .CLK(CLK), .RST(RST), .En(En), .Tick(Tick), .Alive(Alive),
        .X_pos(X_pos), .Y_pos(Y_pos), .Dir(Dir), .Step(Step), .Invaded(Invaded)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int x;
        int y;
        int dir;
        int inv;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_steps = 0;

    int   m_x, m_y, m_cnt;
    bit   m_dir, m_done, m_run;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Monitor: every Step pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && Step) begin
            n_steps++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_step: got Step=1 X=%0d Y=%0d at cycle %0d, required no step",
                         X_pos, Y_pos, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("step_x", int'(X_pos), mon_e.x);
                check("step_y", int'(Y_pos), mon_e.y);
                check("step_dir", int'(Dir), mon_e.dir);
                check("step_invaded", int'(Invaded), mon_e.inv);
                check("step_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic model_reset();
        m_x = 32; m_y = 48; m_dir = 1'b1; m_cnt = 0; m_done = 1'b0;
    endtask

    task automatic model_tick(input int c0);
        int   p;
        exp_t e;
        if (!m_run || m_done || Alive == 6'd0) return;
        p = 2 + int'(Alive);
        if (m_cnt >= p - 1) begin
            m_cnt = 0;
            if (m_dir ? (m_x + 8 <= 400) : (m_x >= 24)) begin
                m_x = m_dir ? m_x + 8 : m_x - 8;
            end else begin
                m_y   = m_y + 16;
                m_dir = !m_dir;
                if (m_y >= 400) m_done = 1'b1;
            end
            e.x = m_x; e.y = m_y; e.dir = int'(m_dir); e.inv = int'(m_done);
            e.cyc = c0 + 2;
            sb.push_back(e);
        end else begin
            m_cnt++;
        end
    endtask

    // One Tick pulse followed by idle cycles; returns 1 time unit after an edge.
    task automatic tick();
        @(posedge CLK); #1;
        Tick = 1'b1;
        model_tick(cyc);
        @(posedge CLK); #1;
        Tick = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic set_en(input bit v);
        @(posedge CLK); #1;
        En = v;
        m_run = v;
        if (!v) model_reset();
    endtask

    task automatic step_once();
        int s;
        s = n_steps;
        for (int i = 0; i < 100 && n_steps == s; i++) tick();
        check("step_arrived", int'(n_steps != s), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, int'(X_pos), 32);
        check({tag, "_y"}, int'(Y_pos), 48);
        check({tag, "_dir"}, int'(Dir), 1);
        check({tag, "_step"}, int'(Step), 0);
        check({tag, "_invaded"}, int'(Invaded), 0);
    endtask

    initial begin
        int s;
        RST = 1'b1; En = 1'b0; Tick = 1'b0; Alive = 6'd10; m_run = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        check_reset_outputs("reset");

        // Idle: ticks with En low change nothing.
        for (int i = 0; i < 20; i++) begin
            tick();
            check_reset_outputs("idle");
        end

        // Step period with Alive=10 (P=12).
        set_en(1'b1);
        for (int i = 0; i < 11; i++) tick();
        check("period_no_early_step", n_steps, 0);
        tick();
        check("period_first_x", int'(X_pos), 40);
        for (int i = 0; i < 12; i++) tick();
        check("period_second_x", int'(X_pos), 48);
        check("period_step_count", n_steps, 2);

        // Right edge with Alive=1 (P=3).
        Alive = 6'd1;
        for (int i = 0; i < 100 && X_pos != 10'd400; i++) step_once();
        check("right_reached", int'(X_pos), 400);
        step_once();
        check("right_edge_y", int'(Y_pos), 64);
        check("right_edge_dir", int'(Dir), 0);
        check("right_edge_x", int'(X_pos), 400);
        step_once();
        check("right_after_x", int'(X_pos), 392);

        // Left edge.
        for (int i = 0; i < 100 && X_pos != 10'd16; i++) step_once();
        check("left_reached", int'(X_pos), 16);
        step_once();
        check("left_edge_y", int'(Y_pos), 80);
        check("left_edge_dir", int'(Dir), 1);
        check("left_edge_x", int'(X_pos), 16);

        // Invasion: march until the final drop from Y=384 at the left edge.
        for (int i = 0; i < 2000 && !Invaded; i++) step_once();
        check("invaded_flag", int'(Invaded), 1);
        check("invaded_y", int'(Y_pos), 400);
        check("invaded_x", int'(X_pos), 16);
        check("invaded_dir", int'(Dir), 1);
        s = n_steps;
        for (int i = 0; i < 200; i++) tick();
        check("done_no_steps", n_steps, s);
        check("done_invaded_sticky", int'(Invaded), 1);
        check("done_y_frozen", int'(Y_pos), 400);

        // One cycle of En low clears everything.
        @(posedge CLK); #1;
        En = 1'b0;
        @(posedge CLK); #1;
        check_reset_outputs("en_drop");
        En = 1'b1;
        m_run = 1'b1;
        model_reset();

        // Alive 40 -> 0 mid-period halts stepping; Alive=1 resumes at P=3.
        Alive = 6'd40;
        for (int i = 0; i < 10; i++) tick();
        Alive = 6'd0;
        s = n_steps;
        for (int i = 0; i < 60; i++) tick();
        check("alive0_no_steps", n_steps, s);
        check("alive0_x", int'(X_pos), 32);
        Alive = 6'd1;
        tick();
        check("speedup_immediate_x", int'(X_pos), 40);
        tick();
        tick();
        check("speedup_gap", n_steps, s + 1);
        tick();
        check("speedup_x", int'(X_pos), 48);

        // En falls on the very cycle of a qualifying Tick.
        tick();
        tick();
        s = n_steps;
        @(posedge CLK); #1;
        Tick = 1'b1; En = 1'b0; m_run = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        Tick = 1'b0;
        check_reset_outputs("prio");
        repeat (3) @(posedge CLK);
        #1;
        check("prio_no_step", n_steps, s);
        set_en(1'b1);
        tick();
        tick();
        check("prio_counter_cleared", n_steps, s);
        tick();
        check("prio_resume_x", int'(X_pos), 40);

        // Asynchronous reset while the formation is in MOVE.
        tick();
        tick();
        s = n_steps;
        @(posedge CLK); #1;
        Tick = 1'b1;
        @(posedge CLK); #1;
        Tick = 1'b0;
        #1 RST = 1'b1;
        #1;
        check("async_rst_x", int'(X_pos), 32);
        check("async_rst_step", int'(Step), 0);
        @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        model_reset();
        check_reset_outputs("async_rst_hold");
        check("async_rst_no_step", n_steps, s);
        tick();
        tick();
        tick();
        check("async_rst_resume_x", int'(X_pos), 40);

        repeat (4) @(posedge CLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
